// File: rtl/b_calc_pkg.sv
// Shared calculator types and constants: entry FSM states, operator codes,
// keypad codes and the sign helper used by the operand accumulator.
package b_calc_pkg;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        WAIT_ALU,
        RESULT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ASL  = 4'hB;
    localparam logic [3:0] OP_NONE = 4'hF;

    localparam int         MAX_DIGITS_DEF = 3;
    localparam logic [3:0] KEY_EQ_DEF     = 4'hA;
    localparam logic [3:0] KEY_CLR_DEF    = 4'hB;

    function automatic logic [7:0] apply_sign(input logic [7:0] mag, input logic neg);
        return neg ? (~mag + 8'd1) : mag;
    endfunction

endpackage

// File: rtl/b_entry_digit_acc.sv
// Combinational decimal accumulator: mag*10+d, range check against the
// signed 8-bit limit for the current sign, and two's-complement result.
module b_entry_digit_acc
    import b_calc_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
    input  logic [7:0] mag,
    input  logic       sign,
    input  logic [3:0] count,
    input  logic [3:0] digit,
    output logic [7:0] mag_next,
    output logic [7:0] value,
    output logic       accept
);

    logic [9:0] prod;
    logic [9:0] limit;

    always_comb begin
        prod     = 10'(mag) * 10'd10 + 10'(digit);
        // Negative operands may reach 128 because -128 is representable.
        limit    = sign ? 10'd128 : 10'd127;
        accept   = (count < 4'(MAX_DIGITS)) && (digit <= 4'd9) && (prod <= limit);
        mag_next = prod[7:0];
        value    = apply_sign(mag_next, sign);
    end

endmodule

// File: rtl/b_entry.sv
// Operand/operator entry sequencer feeding the ALU.
// Build option: B_ENTRY_CHAIN_EN lets an operator in RESULT reuse the result as operand A.
module b_entry
    import b_calc_pkg::*;
#(
    parameter int         MAX_DIGITS = MAX_DIGITS_DEF,
    parameter logic [3:0] KEY_EQ     = KEY_EQ_DEF,
    parameter logic [3:0] KEY_CLR    = KEY_CLR_DEF
) (
    input  logic       i_sys_clock,
    input  logic       i_sys_reset,
    input  logic [3:0] i_b_entry_hex_keycode,
    input  logic       i_b_entry_hex_valid,
    input  logic [3:0] i_b_entry_op_keycode,
    input  logic       i_b_entry_op_valid,
    input  logic       i_b_entry_neg_flag,
    input  logic       i_b_entry_alu_done,
    input  logic [7:0] i_b_entry_alu_result,
    output logic       o_b_entry_hex_new_input,
    output logic [7:0] o_b_entry_operand_a,
    output logic [7:0] o_b_entry_operand_b,
    output logic [3:0] o_b_entry_opcode,
    output logic       o_b_entry_start,
    output logic [7:0] o_b_entry_disp_value,
    output logic       o_b_entry_err
);

    state_t     state;
    logic [7:0] mag;
    logic       sign;
    logic [3:0] count;
    logic       neg_q;

    logic       neg_rise, is_digit, is_eq, clr_req, op_load;
    logic [7:0] acc_mag_in, acc_mag, acc_value, tog_value;
    logic       acc_sign_in, acc_ok;
    logic [3:0] acc_count_in;

    assign neg_rise = i_b_entry_neg_flag & ~neg_q;
    assign is_digit = i_b_entry_hex_keycode <= 4'd9;
    assign is_eq    = i_b_entry_hex_keycode == KEY_EQ;
    assign clr_req  = i_b_entry_hex_valid && (i_b_entry_hex_keycode == KEY_CLR) && (state != WAIT_ALU);

`ifdef B_ENTRY_CHAIN_EN
    assign op_load = !i_b_entry_hex_valid && i_b_entry_op_valid &&
                     ((state == ENTER_A) || (state == RESULT));
`else
    assign op_load = !i_b_entry_hex_valid && i_b_entry_op_valid && (state == ENTER_A);
`endif

    // A digit in RESULT starts a fresh operand, so the accumulator sees an empty one.
    assign acc_mag_in   = (state == RESULT) ? 8'd0 : mag;
    assign acc_sign_in  = (state == RESULT) ? 1'b0 : sign;
    assign acc_count_in = (state == RESULT) ? 4'd0 : count;
    assign tog_value    = apply_sign(mag, ~sign);

    b_entry_digit_acc #(.MAX_DIGITS(MAX_DIGITS)) u_digit_acc (
        .mag      (acc_mag_in),
        .sign     (acc_sign_in),
        .count    (acc_count_in),
        .digit    (i_b_entry_hex_keycode),
        .mag_next (acc_mag),
        .value    (acc_value),
        .accept   (acc_ok)
    );

    always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
        if (!i_sys_reset) begin
            state                   <= ENTER_A;
            mag                     <= 8'd0;
            sign                    <= 1'b0;
            count                   <= 4'd0;
            neg_q                   <= 1'b0;
            o_b_entry_hex_new_input <= 1'b0;
            o_b_entry_operand_a     <= 8'd0;
            o_b_entry_operand_b     <= 8'd0;
            o_b_entry_opcode        <= OP_NONE;
            o_b_entry_start         <= 1'b0;
            o_b_entry_disp_value    <= 8'd0;
            o_b_entry_err           <= 1'b0;
        end else begin
            neg_q                   <= i_b_entry_neg_flag;
            o_b_entry_hex_new_input <= 1'b0;
            o_b_entry_start         <= 1'b0;
            o_b_entry_err           <= 1'b0;
            if (clr_req) begin
                state                <= ENTER_A;
                mag                  <= 8'd0;
                sign                 <= 1'b0;
                count                <= 4'd0;
                o_b_entry_operand_a  <= 8'd0;
                o_b_entry_operand_b  <= 8'd0;
                o_b_entry_opcode     <= OP_NONE;
                o_b_entry_disp_value <= 8'd0;
                o_b_entry_err        <= i_b_entry_op_valid;
            end else begin
                case (state)
                    ENTER_A, ENTER_B: begin
                        if (i_b_entry_hex_valid) begin
                            o_b_entry_err <= i_b_entry_op_valid;
                            if (is_digit) begin
                                if (acc_ok) begin
                                    mag                     <= acc_mag;
                                    count                   <= count + 4'd1;
                                    o_b_entry_hex_new_input <= 1'b1;
                                    o_b_entry_disp_value    <= acc_value;
                                    if (state == ENTER_A) o_b_entry_operand_a <= acc_value;
                                    else                  o_b_entry_operand_b <= acc_value;
                                end else begin
                                    o_b_entry_err <= 1'b1;
                                end
                            end else if (is_eq) begin
                                if (state == ENTER_B) begin
                                    state           <= EXEC;
                                    o_b_entry_start <= 1'b1;
                                end else begin
                                    o_b_entry_err <= 1'b1;
                                end
                            end
                        end else if (i_b_entry_op_valid) begin
                            o_b_entry_opcode <= i_b_entry_op_keycode;
                        end else if (neg_rise) begin
                            // +128 does not fit, so -128 cannot be flipped back.
                            if ((mag == 8'd128) && sign) begin
                                o_b_entry_err <= 1'b1;
                            end else begin
                                sign                 <= ~sign;
                                o_b_entry_disp_value <= tog_value;
                                if (state == ENTER_A) o_b_entry_operand_a <= tog_value;
                                else                  o_b_entry_operand_b <= tog_value;
                            end
                        end
                    end
                    EXEC: state <= WAIT_ALU;
                    WAIT_ALU: begin
                        if (i_b_entry_alu_done) begin
                            o_b_entry_disp_value <= i_b_entry_alu_result;
                            state                <= RESULT;
                        end
                    end
                    RESULT: begin
                        if (i_b_entry_hex_valid) begin
                            o_b_entry_err <= i_b_entry_op_valid;
                            if (is_digit) begin
                                state                   <= ENTER_A;
                                mag                     <= acc_mag;
                                sign                    <= 1'b0;
                                count                   <= 4'd1;
                                o_b_entry_operand_a     <= acc_value;
                                o_b_entry_operand_b     <= 8'd0;
                                o_b_entry_opcode        <= OP_NONE;
                                o_b_entry_disp_value    <= acc_value;
                                o_b_entry_hex_new_input <= 1'b1;
                            end else if (is_eq) begin
                                o_b_entry_err <= 1'b1;
                            end
                        end else if (i_b_entry_op_valid) begin
`ifdef B_ENTRY_CHAIN_EN
                            o_b_entry_operand_a <= o_b_entry_disp_value;
`else
                            o_b_entry_err <= 1'b1;
`endif
                        end
                    end
                    default: state <= ENTER_A;
                endcase
                if (op_load) begin
                    o_b_entry_opcode     <= i_b_entry_op_keycode;
                    o_b_entry_operand_b  <= 8'd0;
                    o_b_entry_disp_value <= 8'd0;
                    mag                  <= 8'd0;
                    sign                 <= 1'b0;
                    count                <= 4'd0;
                    if (i_b_entry_op_keycode == OP_NOT) begin
                        state           <= EXEC;
                        o_b_entry_start <= 1'b1;
                    end else begin
                        state <= ENTER_B;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_b_entry.sv
// Directed self-checking bench for b_entry (default build; chain path under B_ENTRY_CHAIN_EN).
module tb_b_entry;
    import b_calc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] hk = 4'd0;
    logic       hv = 1'b0;
    logic [3:0] ok = 4'd0;
    logic       ov = 1'b0;
    logic       neg = 1'b0;
    logic       ad = 1'b0;
    logic [7:0] ar = 8'd0;
    logic       hnew, start, err;
    logic [7:0] a, b, disp;
    logic [3:0] opc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    b_entry dut (
        .i_sys_clock             (clk),
        .i_sys_reset             (rst_n),
        .i_b_entry_hex_keycode   (hk),
        .i_b_entry_hex_valid     (hv),
        .i_b_entry_op_keycode    (ok),
        .i_b_entry_op_valid      (ov),
        .i_b_entry_neg_flag      (neg),
        .i_b_entry_alu_done      (ad),
        .i_b_entry_alu_result    (ar),
        .o_b_entry_hex_new_input (hnew),
        .o_b_entry_operand_a     (a),
        .o_b_entry_operand_b     (b),
        .o_b_entry_opcode        (opc),
        .o_b_entry_start         (start),
        .o_b_entry_disp_value    (disp),
        .o_b_entry_err           (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic hv_i, input logic [3:0] hk_i, input logic ov_i,
                       input logic [3:0] ok_i, input logic ad_i, input logic [7:0] ar_i);
        @(negedge clk);
        hv = hv_i; hk = hk_i; ov = ov_i; ok = ok_i; ad = ad_i; ar = ar_i;
        @(posedge clk);
        #1;
        hv = 1'b0; ov = 1'b0; ad = 1'b0;
    endtask

    task automatic hex(input logic [3:0] k);  cyc(1'b1, k, 1'b0, 4'd0, 1'b0, 8'd0); endtask
    task automatic op(input logic [3:0] k);   cyc(1'b0, 4'd0, 1'b1, k, 1'b0, 8'd0); endtask
    task automatic alu(input logic [7:0] r);  cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, r); endtask
    task automatic idle();                    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'd0); endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", a, 8'd0);
        chk("rst_b", b, 8'd0);
        chk("rst_disp", disp, 8'd0);
        chk("rst_opcode", opc, 4'hF);
        chk("rst_pulses", {start, err, hnew}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // 1,2,7 -> 127; an 8 is rejected
        hex(4'd1); chk("d1_a", a, 8'd1); chk("d1_hnew", hnew, 1'b1);
        hex(4'd2); chk("d12_a", a, 8'd12);
        hex(4'd7); chk("d127_a", a, 8'd127); chk("d127_disp", disp, 8'd127);
        hex(4'd8); chk("d1278_err", err, 1'b1); chk("d1278_hnew", hnew, 1'b0);
        chk("d1278_a", a, 8'd127);
        idle(); chk("err_one_cycle", err, 1'b0);

        // negative entry down to -128; a second sign flip is refused
        hex(KEY_CLR_DEF); chk("clr_a", a, 8'd0);
        neg = 1'b1; idle(); chk("neg0_a", a, 8'd0); chk("neg0_err", err, 1'b0);
        hex(4'd1); chk("n1_a", a, 8'hFF);
        neg = 1'b0;
        hex(4'd2); chk("n12_a", a, 8'hF4);
        hex(4'd8); chk("n128_a", a, 8'h80); chk("n128_err", err, 1'b0);
        neg = 1'b1; idle(); chk("n128_flip_err", err, 1'b1); chk("n128_flip_a", a, 8'h80);
        neg = 1'b0;

        // 5 + 3 =
        hex(KEY_CLR_DEF);
        hex(4'd5); op(OP_ADD);
        chk("add_op", opc, OP_ADD); chk("add_b0", b, 8'd0);
        hex(4'd3); chk("add_b", b, 8'd3); chk("add_disp_b", disp, 8'd3);
        hex(KEY_EQ_DEF); chk("add_start", start, 1'b1);
        chk("add_ab", {a, b}, {8'd5, 8'd3});
        idle(); chk("add_start_once", start, 1'b0);
        hex(4'd7); chk("wait_no_err", err, 1'b0); chk("wait_b_held", b, 8'd3);
        chk("wait_disp", disp, 8'd3);
        alu(8'd8); chk("add_disp", disp, 8'd8);

        // EQ in RESULT is illegal
        hex(KEY_EQ_DEF); chk("res_eq_err", err, 1'b1); chk("res_eq_disp", disp, 8'd8);
`ifdef B_ENTRY_CHAIN_EN
        op(OP_SUB); chk("chain_a", a, 8'd8); chk("chain_op", opc, OP_SUB);
        chk("chain_err", err, 1'b0);
        hex(4'd2); chk("chain_b", b, 8'd2);
        hex(KEY_EQ_DEF); chk("chain_start", start, 1'b1);
        idle();
        alu(8'd6); chk("chain_disp", disp, 8'd6);
`else
        op(OP_SUB); chk("nochain_err", err, 1'b1); chk("nochain_disp", disp, 8'd8);
        hex(4'd2); chk("res_digit_a", a, 8'd2); chk("res_digit_hnew", hnew, 1'b1);
        hex(KEY_EQ_DEF); chk("enter_a_eq_err", err, 1'b1); chk("enter_a_eq_start", start, 1'b0);
`endif

        // unary NOT goes straight to execute
        hex(KEY_CLR_DEF);
        hex(4'd9); op(OP_NOT);
        chk("not_start", start, 1'b1); chk("not_op", opc, OP_NOT);
        chk("not_ab", {a, b}, {8'd9, 8'd0});
        idle(); chk("not_start_once", start, 1'b0);
        alu(8'hF6); chk("not_disp", disp, 8'hF6);
        hex(KEY_CLR_DEF); chk("res_clr_disp", disp, 8'd0); chk("res_clr_op", opc, 4'hF);

        // digit and operator together: digit wins, operator dropped with err
        cyc(1'b1, 4'd3, 1'b1, OP_SUB, 1'b0, 8'd0);
        chk("both_a", a, 8'd3); chk("both_err", err, 1'b1); chk("both_op", opc, 4'hF);

        // reset during WAIT_ALU discards the pending result
        hex(KEY_CLR_DEF);
        hex(4'd4); op(OP_ADD); hex(4'd1); hex(KEY_EQ_DEF); idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ab", {a, b}, 16'd0); chk("async_rst_op", opc, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        alu(8'h55);
        chk("post_rst_disp", disp, 8'd0); chk("post_rst_start", start, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
